// File: rtl/r5p_htif_sub_pkg.sv
// Shared HTIF definitions for the r5p HTIF responder.
//  - HTIF device/command codes recognised in a tohost word
//  - htif_cmd_t: field view of a 32-bit tohost word
//  - htif_state_t: responder run state
//  - HTIF_ACK: value posted to fromhost after a console putchar
package r5p_htif_sub_pkg;

    localparam logic [7:0] HTIF_DEV_CONSOLE = 8'd1;
    localparam logic [7:0] HTIF_CMD_PUTC    = 8'd1;

    // fromhost acknowledge after a console putchar: dev=1, cmd=1, payload=1
    localparam logic [31:0] HTIF_ACK = {8'h01, 8'h01, 16'h0001};

    typedef struct packed {
        logic [7:0]  dev;
        logic [7:0]  cmd;
        logic [15:0] pld;
    } htif_cmd_t;

    typedef enum logic [1:0] {
        HTIF_RUN  = 2'd0,
        HTIF_HALT = 2'd1,
        HTIF_TOUT = 2'd2
    } htif_state_t;

endpackage

// File: rtl/r5p_htif_sub_fifo.sv
// Synchronous FIFO holding console characters.
//  clk, rst   clock, synchronous active-high reset (pointers only)
//  push, pdat write strobe and data (ignored when full unless popping)
//  pop        read strobe (ignored when empty)
//  head       oldest entry, valid while !empty
//  full/empty occupancy flags
module r5p_htif_sub_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pdat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit separates full (MSBs differ) from empty (equal).
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head  = mem_q[rptr_q[AW-1:0]];

    // Push while full is accepted only when the head leaves the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= pdat;
    end

endmodule

// File: rtl/r5p_htif_sub.sv
// HTIF responder on a TCB subordinate port (byte-enable mode).
// Decodes core accesses to the tohost/fromhost words, streams console
// putchar characters through a FIFO, latches halt/exit code on a pass/fail
// write and flags a timeout when the run lasts too long.
//  clk, rst             clock, synchronous active-high reset
//  tcb_vld/tcb_rdy      request handshake (rdy drops only while FIFO full)
//  tcb_req_*            write enable, byte address, byte enables, write data
//  tcb_rsp_rdt/_sts     response, valid the cycle after the transfer
//  con_vld/rdy/dat      console character stream
//  halt, exit_code      sticky test-finished flag and tohost[31:1]
//  timeout              sticky timeout flag
module r5p_htif_sub
    import r5p_htif_sub_pkg::*;
#(
    parameter int unsigned ADR_W   = 32,
    parameter int unsigned DAT_W   = 32,
    parameter logic [31:0] TOHOST  = 32'h0,
    parameter int unsigned FIFO_D  = 8,
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tcb_vld,
    output logic               tcb_rdy,
    input  logic               tcb_req_wen,
    input  logic [ADR_W-1:0]   tcb_req_adr,
    input  logic [DAT_W/8-1:0] tcb_req_byt,
    input  logic [DAT_W-1:0]   tcb_req_wdt,
    output logic [DAT_W-1:0]   tcb_rsp_rdt,
    output logic               tcb_rsp_sts,
    output logic               con_vld,
    input  logic               con_rdy,
    output logic [7:0]         con_dat,
    output logic               halt,
    output logic [30:0]        exit_code,
    output logic               timeout
);

    localparam int unsigned BYT_W   = DAT_W / 8;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    function automatic logic [DAT_W-1:0] byte_merge(
        input logic [DAT_W-1:0] old,
        input logic [DAT_W-1:0] wdt,
        input logic [BYT_W-1:0] byt
    );
        logic [DAT_W-1:0] r;
        r = old;
        for (int i = 0; i < BYT_W; i++) begin
            if (byt[i]) r[8*i +: 8] = wdt[8*i +: 8];
        end
        return r;
    endfunction

    htif_state_t      state_q, state_d;
    logic [DAT_W-1:0] tohost_q, tohost_d;
    logic [DAT_W-1:0] fromhost_q, fromhost_d;
    logic [DAT_W-1:0] rdt_q, rdt_d;
    logic             sts_q, sts_d;
    logic [30:0]      exit_code_q, exit_code_d;
    logic [31:0]      cnt_q, cnt_d;

    logic             trn;
    logic [1:0]       off;
    htif_cmd_t        cmd;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic             unused_adr;

    assign trn = tcb_vld & tcb_rdy;
    // Word offset of the access relative to the tohost word.
    assign off = tcb_req_adr[3:2] - TOHOST[3:2];
    assign cmd = htif_cmd_t'(tcb_req_wdt[31:0]);
    assign unused_adr = ^{tcb_req_adr[ADR_W-1:4], tcb_req_adr[1:0]};

    always_comb begin
        state_d     = state_q;
        tohost_d    = tohost_q;
        fromhost_d  = fromhost_q;
        rdt_d       = rdt_q;
        sts_d       = sts_q;
        exit_code_d = exit_code_q;
        cnt_d       = cnt_q;
        fifo_push   = 1'b0;

        if (trn) begin
            rdt_d = '0;
            sts_d = 1'b0;
            unique case (off)
                2'd0: begin
                    if (!tcb_req_wen) begin
                        rdt_d = tohost_q;
                    end else if (state_q == HTIF_RUN) begin
                        tohost_d = byte_merge(tohost_q, tcb_req_wdt, tcb_req_byt);
                        // Only whole-word writes are HTIF commands. Putchar is
                        // checked first because the character may have bit 0 set.
                        if (&tcb_req_byt) begin
                            if (cmd.dev == HTIF_DEV_CONSOLE && cmd.cmd == HTIF_CMD_PUTC) begin
                                fifo_push  = 1'b1;
                                tohost_d   = '0;
                                fromhost_d = HTIF_ACK;
                            end else if (tcb_req_wdt[0]) begin
                                state_d     = HTIF_HALT;
                                exit_code_d = tcb_req_wdt[31:1];
                            end
                        end
                    end
                end
                2'd1: begin
                    if (!tcb_req_wen) begin
                        rdt_d = fromhost_q;
                    end else if (state_q == HTIF_RUN) begin
                        fromhost_d = byte_merge(fromhost_q, tcb_req_wdt, tcb_req_byt);
                    end
                end
                default: sts_d = 1'b1;
            endcase
        end

        // Cycle counter runs only in RUN, so a halt freezes it; a halt write
        // in the same cycle as the limit wins over the timeout.
        if (state_q == HTIF_RUN) begin
            if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
            if (TIMEOUT != 0 && cnt_q == TO_LAST && state_d == HTIF_RUN) state_d = HTIF_TOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HTIF_RUN;
            tohost_q    <= '0;
            fromhost_q  <= '0;
            rdt_q       <= '0;
            sts_q       <= 1'b0;
            exit_code_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            tohost_q    <= tohost_d;
            fromhost_q  <= fromhost_d;
            rdt_q       <= rdt_d;
            sts_q       <= sts_d;
            exit_code_q <= exit_code_d;
            cnt_q       <= cnt_d;
        end
    end

    r5p_htif_sub_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pdat  (tcb_req_wdt[7:0]),
        .pop   (fifo_pop),
        .head  (con_dat),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_pop    = con_vld & con_rdy;
    assign con_vld     = ~fifo_empty;
    assign tcb_rdy     = ~fifo_full;
    assign tcb_rsp_rdt = rdt_q;
    assign tcb_rsp_sts = sts_q;
    assign halt        = (state_q == HTIF_HALT);
    assign timeout     = (state_q == HTIF_TOUT);
    assign exit_code   = exit_code_q;

endmodule

// File: tb/tb_r5p_htif_sub.sv
module tb_r5p_htif_sub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tcb_vld = 1'b0;
    logic        tcb_rdy;
    logic        tcb_req_wen = 1'b0;
    logic [31:0] tcb_req_adr = '0;
    logic [3:0]  tcb_req_byt = '0;
    logic [31:0] tcb_req_wdt = '0;
    logic [31:0] tcb_rsp_rdt;
    logic        tcb_rsp_sts;
    logic        con_vld;
    logic        con_rdy = 1'b0;
    logic [7:0]  con_dat;
    logic        halt;
    logic [30:0] exit_code;
    logic        timeout;

    int total = 0;
    int bad   = 0;
    logic [7:0] got[$];

    always #5 clk = ~clk;

    r5p_htif_sub #(
        .ADR_W   (32),
        .DAT_W   (32),
        .TOHOST  (32'h0),
        .FIFO_D  (8),
        .TIMEOUT (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tcb_vld     (tcb_vld),
        .tcb_rdy     (tcb_rdy),
        .tcb_req_wen (tcb_req_wen),
        .tcb_req_adr (tcb_req_adr),
        .tcb_req_byt (tcb_req_byt),
        .tcb_req_wdt (tcb_req_wdt),
        .tcb_rsp_rdt (tcb_rsp_rdt),
        .tcb_rsp_sts (tcb_rsp_sts),
        .con_vld     (con_vld),
        .con_rdy     (con_rdy),
        .con_dat     (con_dat),
        .halt        (halt),
        .exit_code   (exit_code),
        .timeout     (timeout)
    );

    // Record every character that leaves the console port.
    always @(negedge clk) begin
        if (!rst && con_vld && con_rdy) got.push_back(con_dat);
    end

    typedef struct {
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  byt;
        logic [31:0] wdt;
        logic        chk_rdt;
        logic [31:0] exp_rdt;
        logic        exp_sts;
        logic        exp_halt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic xfer(input logic wen, input logic [31:0] adr, input logic [3:0] byt,
                        input logic [31:0] wdt, output logic [31:0] rdt, output logic sts);
        int n;
        n = 0;
        tcb_vld = 1'b1; tcb_req_wen = wen; tcb_req_adr = adr;
        tcb_req_byt = byt; tcb_req_wdt = wdt;
        while (!tcb_rdy && n < 200) begin
            tick(1);
            n++;
        end
        chk("xfer_rdy", {31'b0, tcb_rdy}, 32'h1);
        tick(1);
        tcb_vld = 1'b0;
        rdt = tcb_rsp_rdt;
        sts = tcb_rsp_sts;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vt[8];
        logic [31:0] rdt;
        logic        sts;
        int          n;

        vt[0] = '{1'b0, 32'h8,  4'hf, 32'h0,        1'b1, 32'h0,    1'b1, 1'b0};
        vt[1] = '{1'b0, 32'hc,  4'hf, 32'h0,        1'b1, 32'h0,    1'b1, 1'b0};
        vt[2] = '{1'b1, 32'h0,  4'h1, 32'h0000_0001, 1'b0, 32'h0,    1'b0, 1'b0};
        vt[3] = '{1'b0, 32'h0,  4'hf, 32'h0,        1'b1, 32'h1,    1'b0, 1'b0};
        vt[4] = '{1'b1, 32'h0,  4'h2, 32'h0000_ab00, 1'b0, 32'h0,    1'b0, 1'b0};
        vt[5] = '{1'b1, 32'h8,  4'hf, 32'hffff_ffff, 1'b1, 32'h0,    1'b1, 1'b0};
        vt[6] = '{1'b0, 32'h0,  4'hf, 32'h0,        1'b1, 32'hab01, 1'b0, 1'b0};
        vt[7] = '{1'b1, 32'h4,  4'hf, 32'h1234_5678, 1'b0, 32'h0,    1'b0, 1'b0};

        // Reset state
        tick(2);
        rst = 1'b0;
        chk("rst_rdy",  {31'b0, tcb_rdy}, 32'h1);
        chk("rst_rdt",  tcb_rsp_rdt, 32'h0);
        chk("rst_sts",  {31'b0, tcb_rsp_sts}, 32'h0);
        chk("rst_cvld", {31'b0, con_vld}, 32'h0);
        chk("rst_halt", {31'b0, halt}, 32'h0);
        chk("rst_exit", {1'b0, exit_code}, 32'h0);
        chk("rst_tout", {31'b0, timeout}, 32'h0);

        // Single putchar with console ready
        con_rdy = 1'b1;
        got.delete();
        xfer(1'b1, 32'h0, 4'hf, 32'h0101_0041, rdt, sts);
        chk("t1_cvld", {31'b0, con_vld}, 32'h1);
        chk("t1_cdat", {24'b0, con_dat}, 32'h41);
        tick(1);
        chk("t1_cvld_off", {31'b0, con_vld}, 32'h0);
        xfer(1'b0, 32'h4, 4'hf, 32'h0, rdt, sts);
        chk("t1_fromhost", rdt, 32'h0101_0001);
        xfer(1'b0, 32'h0, 4'hf, 32'h0, rdt, sts);
        chk("t1_tohost", rdt, 32'h0);
        chk("t1_nchar", got.size(), 32'd1);
        if (got.size() > 0) chk("t1_char", {24'b0, got[0]}, 32'h41);

        // Nine putchars into an 8-deep FIFO with the console stalled
        do_reset();
        con_rdy = 1'b0;
        got.delete();
        for (int i = 0; i < 8; i++) xfer(1'b1, 32'h0, 4'hf, 32'h0101_0061 + i, rdt, sts);
        tcb_vld = 1'b1; tcb_req_wen = 1'b1; tcb_req_adr = 32'h0;
        tcb_req_byt = 4'hf; tcb_req_wdt = 32'h0101_0069;
        chk("t2_full_rdy0", {31'b0, tcb_rdy}, 32'h0);
        tick(3);
        chk("t2_stall_rdy0", {31'b0, tcb_rdy}, 32'h0);
        con_rdy = 1'b1;
        n = 0;
        while (!tcb_rdy && n < 20) begin
            tick(1);
            n++;
        end
        chk("t2_rdy_back", {31'b0, tcb_rdy}, 32'h1);
        tick(1);
        tcb_vld = 1'b0;
        tick(15);
        chk("t2_nchar", got.size(), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < got.size()) chk("t2_char", {24'b0, got[i]}, 32'h61 + i);
        end
        chk("t2_empty", {31'b0, con_vld}, 32'h0);

        // Halt with exit code 0, later writes ignored, counter frozen
        do_reset();
        xfer(1'b1, 32'h0, 4'hf, 32'h0000_0001, rdt, sts);
        chk("t3_halt", {31'b0, halt}, 32'h1);
        chk("t3_exit", {1'b0, exit_code}, 32'h0);
        xfer(1'b1, 32'h0, 4'hf, 32'h0000_0007, rdt, sts);
        chk("t3_exit_keep", {1'b0, exit_code}, 32'h0);
        chk("t3_halt_keep", {31'b0, halt}, 32'h1);
        xfer(1'b0, 32'h0, 4'hf, 32'h0, rdt, sts);
        chk("t3_tohost_keep", rdt, 32'h1);
        tick(150);
        chk("t3_no_tout", {31'b0, timeout}, 32'h0);

        // Nonzero exit code
        do_reset();
        xfer(1'b1, 32'h0, 4'hf, 32'h0000_000b, rdt, sts);
        chk("t3b_exit", {1'b0, exit_code}, 32'h5);

        // Error offsets and partial writes
        do_reset();
        for (int i = 0; i < 8; i++) begin
            xfer(vt[i].wen, vt[i].adr, vt[i].byt, vt[i].wdt, rdt, sts);
            if (vt[i].chk_rdt) chk($sformatf("t5_rdt%0d", i), rdt, vt[i].exp_rdt);
            chk($sformatf("t5_sts%0d", i), {31'b0, sts}, {31'b0, vt[i].exp_sts});
            chk($sformatf("t5_halt%0d", i), {31'b0, halt}, {31'b0, vt[i].exp_halt});
        end
        xfer(1'b0, 32'h4, 4'hf, 32'h0, rdt, sts);
        chk("t5_fromhost", rdt, 32'h1234_5678);

        // Reset with characters queued and halt set
        do_reset();
        con_rdy = 1'b0;
        for (int i = 0; i < 3; i++) xfer(1'b1, 32'h0, 4'hf, 32'h0101_0031 + i, rdt, sts);
        xfer(1'b1, 32'h0, 4'hf, 32'h0000_0001, rdt, sts);
        chk("t6_pre_halt", {31'b0, halt}, 32'h1);
        chk("t6_pre_cvld", {31'b0, con_vld}, 32'h1);
        rst = 1'b1;
        tick(1);
        chk("t6_cvld", {31'b0, con_vld}, 32'h0);
        chk("t6_halt", {31'b0, halt}, 32'h0);
        chk("t6_rdy",  {31'b0, tcb_rdy}, 32'h1);
        chk("t6_rdt",  tcb_rsp_rdt, 32'h0);
        rst = 1'b0;

        // Timeout exactly 100 cycles after reset release
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            tick(1);
            if (i == 99)  chk("t4_tout_early", {31'b0, timeout}, 32'h0);
            if (i == 100) chk("t4_tout", {31'b0, timeout}, 32'h1);
        end
        chk("t4_halt", {31'b0, halt}, 32'h0);
        xfer(1'b0, 32'hc, 4'hf, 32'h0, rdt, sts);
        chk("t4_sts_err", {31'b0, sts}, 32'h1);
        xfer(1'b1, 32'h0, 4'hf, 32'h0000_0001, rdt, sts);
        chk("t4_no_halt", {31'b0, halt}, 32'h0);
        chk("t4_tout_keep", {31'b0, timeout}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
